// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 5-stage MIPS pipeline.
//
// Chooses the npc value and the pc_en load strobe for the PC register.
// Redirects that arrive while fetch is blocked are buffered. EPC is held for
// eret, and flush_if squashes the IF/ID register when required.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous reset, active low
//   pc           current PC from the PC register
//   stall        hazard-unit stall request
//   imem_ready   instruction memory can accept a fetch this cycle
//   br_taken     ID-stage branch resolved taken, target br_target
//   jump         ID-stage j/jal/jr, target jump_target
//   exc          MEM-stage exception request, exc_pc = excepting PC
//   eret         MEM-stage eret
//   npc          next PC to the PC register
//   pc_en        PC register load enable
//   flush_if     squash IF/ID this cycle
//   epc          saved exception PC
//   state        FSM state (debug)
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | sequential fetch; live redirects taken if fetch is possible
// PEND  | a redirect is buffered, waiting for fetch to be possible
// FLUSH | one cycle after an exc/eret load; branch/jump inputs are stale
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        flush_if,
    output logic [31:0] epc,
    output logic [1:0]  state
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] epc_q;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_sys_q, pend_sys_d;

    logic        fetch_ok;
    logic        live_sys, live_bj;
    logic [31:0] live_sys_tgt, live_bj_tgt, pc_inc;
    logic        take, tgt_sys;
    logic [31:0] tgt;

    always_comb begin
        // exc/eret may bypass a stall, but nothing bypasses imem_ready
        fetch_ok     = imem_ready & (~stall | exc | eret);
        live_sys     = exc | eret;
        live_sys_tgt = exc ? EXC_VECTOR : epc_q;
        live_bj      = jump | br_taken;
        live_bj_tgt  = jump ? jump_target : br_target;
        pc_inc       = pc + 32'd4;

        npc        = pc_inc;
        pc_en      = fetch_ok;
        flush_if   = 1'b0;
        state_d    = RUN;
        pend_tgt_d = pend_tgt_q;
        pend_sys_d = pend_sys_q;

        case (state_q)
            PEND: begin
                // a new exc/eret replaces the buffered target; branch/jump cannot
                take    = 1'b1;
                tgt     = live_sys ? live_sys_tgt : pend_tgt_q;
                tgt_sys = live_sys | pend_sys_q;
            end
            FLUSH: begin
                take    = live_sys;
                tgt     = live_sys_tgt;
                tgt_sys = 1'b1;
            end
            default: begin
                take    = live_sys | live_bj;
                tgt     = live_sys ? live_sys_tgt : live_bj_tgt;
                tgt_sys = live_sys;
            end
        endcase

        if (take) begin
            npc = tgt;
            if (fetch_ok) begin
                flush_if   = tgt_sys | (DELAY_SLOT == 1'b0);
                state_d    = tgt_sys ? FLUSH : RUN;
                pend_tgt_d = '0;
                pend_sys_d = 1'b0;
            end else begin
                state_d    = PEND;
                pend_tgt_d = tgt;
                pend_sys_d = tgt_sys;
            end
        end

        if (!reset) begin
            npc      = RESET_PC;
            pc_en    = 1'b0;
            flush_if = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            epc_q      <= '0;
            pend_tgt_q <= '0;
            pend_sys_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pend_sys_q <= pend_sys_d;
            if (exc) begin
                epc_q <= exc_pc;
            end
        end
    end

    assign epc   = epc_q;
    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall, imem_ready, br_taken, jump, exc, eret;
    logic [31:0] br_target, jump_target, exc_pc;
    logic [31:0] npc, epc, npc0, epc0;
    logic        pc_en, flush_if, pc_en0, flush_if0;
    logic [1:0]  state, state0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.DELAY_SLOT(1'b1)) dut (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall), .imem_ready(imem_ready),
        .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
        .exc(exc), .exc_pc(exc_pc), .eret(eret),
        .npc(npc), .pc_en(pc_en), .flush_if(flush_if), .epc(epc), .state(state)
    );

    pc_sequencer #(.DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall), .imem_ready(imem_ready),
        .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
        .exc(exc), .exc_pc(exc_pc), .eret(eret),
        .npc(npc0), .pc_en(pc_en0), .flush_if(flush_if0), .epc(epc0), .state(state0)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        stall, rdy, br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        exc;
        logic [31:0] xpc;
        logic        eret;
        logic [31:0] e_npc;
        logic        e_en, e_fl, e_fl0;
        logic [1:0]  e_st;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [31:0] p, logic st, logic rdy,
                                logic br, logic [31:0] brt, logic jmp, logic [31:0] jt,
                                logic ex, logic [31:0] xpc, logic er,
                                logic [31:0] e_npc, logic e_en, logic e_fl, logic e_fl0,
                                logic [1:0] e_st, logic [31:0] e_epc);
        vec_t v;
        v.rst = rst; v.pc = p; v.stall = st; v.rdy = rdy; v.br = br; v.brt = brt;
        v.jmp = jmp; v.jt = jt; v.exc = ex; v.xpc = xpc; v.eret = er;
        v.e_npc = e_npc; v.e_en = e_en; v.e_fl = e_fl; v.e_fl0 = e_fl0;
        v.e_st = e_st; v.e_epc = e_epc;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [31:0] p, logic st, logic rdy, logic br,
                         logic [31:0] brt, logic jmp, logic [31:0] jt, logic ex,
                         logic [31:0] xpc, logic er);
        reset = rst; pc = p; stall = st; imem_ready = rdy; br_taken = br;
        br_target = brt; jump = jmp; jump_target = jt; exc = ex; exc_pc = xpc; eret = er;
    endtask

    initial begin
        // rst  pc            stl rdy br brt        jmp jt         exc xpc        eret | npc         en fl fl0 st    epc
        add(0, 32'h0,         0, 0, 0, 0,          0, 0,          0, 0,          0,  32'h3000,    0, 0, 0, 2'd0, 32'h0);
        add(0, 32'h0,         0, 0, 0, 0,          0, 0,          0, 0,          0,  32'h3000,    0, 0, 0, 2'd0, 32'h0);
        add(1, 32'h3000,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h3004,    1, 0, 0, 2'd0, 32'h0);
        add(1, 32'h3004,      0, 1, 1, 32'h3040,   0, 0,          0, 0,          0,  32'h3040,    1, 0, 1, 2'd0, 32'h0);
        add(1, 32'h3040,      1, 1, 0, 0,          1, 32'h3100,   0, 0,          0,  32'h3100,    0, 0, 0, 2'd0, 32'h0);
        add(1, 32'h3040,      1, 1, 1, 32'h3200,   0, 0,          0, 0,          0,  32'h3100,    0, 0, 0, 2'd1, 32'h0);
        add(1, 32'h3040,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h3100,    1, 0, 1, 2'd1, 32'h0);
        add(1, 32'h3100,      1, 1, 0, 0,          0, 0,          1, 32'h3008,   0,  32'h4180,    1, 1, 1, 2'd0, 32'h0);
        add(1, 32'h4180,      0, 1, 1, 32'h3200,   0, 0,          0, 0,          0,  32'h4184,    1, 0, 0, 2'd2, 32'h3008);
        add(1, 32'h4184,      0, 0, 0, 0,          1, 32'h3300,   0, 0,          0,  32'h3300,    0, 0, 0, 2'd0, 32'h3008);
        add(1, 32'h4184,      0, 0, 0, 0,          0, 0,          1, 32'h4184,   0,  32'h4180,    0, 0, 0, 2'd1, 32'h3008);
        add(1, 32'h4184,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h4180,    1, 1, 1, 2'd1, 32'h4184);
        add(1, 32'h4180,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h4184,    1, 0, 0, 2'd2, 32'h4184);
        add(1, 32'h4184,      0, 1, 0, 0,          0, 0,          0, 0,          1,  32'h4184,    1, 1, 1, 2'd0, 32'h4184);
        add(1, 32'h4184,      1, 1, 0, 0,          0, 0,          0, 0,          0,  32'h4188,    0, 0, 0, 2'd2, 32'h4184);
        add(1, 32'h5000,      0, 1, 0, 0,          0, 0,          1, 32'h5000,   1,  32'h4180,    1, 1, 1, 2'd0, 32'h4184);
        add(1, 32'h4180,      0, 0, 0, 0,          0, 0,          0, 0,          1,  32'h5000,    0, 0, 0, 2'd2, 32'h5000);
        add(1, 32'h4180,      0, 0, 0, 0,          0, 0,          0, 0,          0,  32'h5000,    0, 0, 0, 2'd1, 32'h5000);
        add(0, 32'h4180,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h3000,    0, 0, 0, 2'd1, 32'h5000);
        add(1, 32'h3000,      0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h3004,    1, 0, 0, 2'd0, 32'h0);
        add(1, 32'hFFFF_FFFC, 0, 1, 0, 0,          0, 0,          0, 0,          0,  32'h0,       1, 0, 0, 2'd0, 32'h0);
        add(1, 32'h0,         1, 1, 0, 0,          0, 0,          0, 0,          0,  32'h4,       0, 0, 0, 2'd0, 32'h0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].rdy, vecs[i].br,
                  vecs[i].brt, vecs[i].jmp, vecs[i].jt, vecs[i].exc, vecs[i].xpc,
                  vecs[i].eret);
            @(negedge clk);
            chk($sformatf("v%0d npc", i),      npc,       vecs[i].e_npc);
            chk($sformatf("v%0d pc_en", i),    {31'b0, pc_en},     {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d flush_if", i), {31'b0, flush_if},  {31'b0, vecs[i].e_fl});
            chk($sformatf("v%0d flush_if_ds0", i), {31'b0, flush_if0}, {31'b0, vecs[i].e_fl0});
            chk($sformatf("v%0d state", i),    {30'b0, state},     {30'b0, vecs[i].e_st});
            chk($sformatf("v%0d epc", i),      epc,       vecs[i].e_epc);
        end

        // Reset while a jump is buffered: the buffered jump must be lost.
        @(posedge clk); #1;
        drive(1, 32'h10, 1, 1, 0, 0, 1, 32'h3500, 0, 0, 0);
        @(negedge clk);
        chk("seq_stall_jump pc_en", {31'b0, pc_en}, 32'd0);
        @(posedge clk); #1;
        drive(0, 32'h10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seq_pend state", {30'b0, state}, 32'd1);
        chk("seq_rst npc", npc, 32'h3000);
        @(posedge clk); #1;
        drive(1, 32'h3000, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seq_after_rst state", {30'b0, state}, 32'd0);
        chk("seq_after_rst npc", npc, 32'h3004);
        chk("seq_after_rst pc_en", {31'b0, pc_en}, 32'd0);
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        chk("seq_resume npc", npc, 32'h3004);
        chk("seq_resume pc_en", {31'b0, pc_en}, 32'd1);
        chk("seq_resume state", {30'b0, state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 5-stage MIPS pipeline. It sits between the hazard, branch, jump and exception logic and the PC register.
- Each cycle it selects the npc value and the pc_en strobe for the PC register.
- It buffers redirects that arrive while fetch is blocked, and holds EPC for eret.
- It asserts flush_if when the IF/ID instruction must be squashed.

Parameters:
RESET_PC, 32'h00003000, value driven on npc during reset; matches the PC register reset value
EXC_VECTOR, 32'h00004180, exception handler entry address
DELAY_SLOT, 1, 1 = branch/jump keep the delay-slot instruction (no flush_if); 0 = branch/jump flush IF/ID

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk
pc  in  32  current PC from the PC register
stall  in  1  hazard-unit stall request
imem_ready  in  1  instruction memory can accept a fetch this cycle
br_taken  in  1  ID-stage branch resolved taken
br_target  in  32  branch target
jump  in  1  ID-stage j/jal/jr
jump_target  in  32  jump target (register value for jr)
exc  in  1  exception request from MEM stage
exc_pc  in  32  PC of the excepting instruction
eret  in  1  eret in MEM stage
npc  out  32  next PC to the PC register
pc_en  out  1  PC register load enable
flush_if  out  1  squash the IF/ID register this cycle
epc  out  32  saved exception PC
state  out  2  FSM state, for debug: RUN=0, PEND=1, FLUSH=2

Behaviour:
- Reset (reset==0 at posedge):
  - state=RUN, epc=0, pending target/flag cleared.
  - While reset is low: pc_en=0, npc=RESET_PC, flush_if=0.
  - Reset mid-PEND discards the pending redirect.
- Redirect source priority: exc > eret > jump > br_taken. Live targets: EXC_VECTOR, epc, jump_target, br_target.
- fetch_ok = imem_ready & (~stall | exc | eret). Exceptions and eret override stall but never imem_ready.
- npc, pc_en and flush_if are combinational from state, the pending registers and the inputs. The PC register loads npc at the next edge, so a redirect reaches PC one cycle after it is presented.
- RUN:
  - No redirect: npc=pc+4 (mod 2^32, wraps at 32'hFFFFFFFC), pc_en=fetch_ok.
  - Redirect and fetch_ok: npc=target, pc_en=1. On exc or eret go to FLUSH. On jump/branch stay in RUN.
  - Redirect and ~fetch_ok: pc_en=0. Latch target, latch the source class (exc/eret vs branch/jump), go to PEND.
- PEND:
  - A new exc or eret overwrites the pending target. A new jump or branch is ignored.
  - When fetch_ok: npc=pending target, pc_en=1, clear the pending registers. Go to FLUSH if the pending class was exc/eret, else RUN.
  - While ~fetch_ok: pc_en=0, npc=pending target.
- FLUSH (exactly one cycle):
  - br_taken and jump are ignored, because they come from squashed instructions.
  - exc and eret are handled as in RUN.
  - Otherwise npc=pc+4 and pc_en=fetch_ok. Return to RUN unless a new exc/eret is taken.
- flush_if = 1 in the cycle an exc or eret target is loaded (pc_en=1), whether live or pending. For a branch/jump target load it is 1 only if DELAY_SLOT==0.
- epc <= exc_pc on every cycle with exc=1 (outside reset), independent of fetch_ok. When exc and eret are both high, exc wins and eret is dropped.
- pc_en is never 1 while stall=1, except when loading an exc or eret target.

Test Plan:
- Reset and sequential fetch: reset=0 for 2 cycles → pc_en=0, npc=32'h3000. Release with pc=32'h3000, no stall, imem_ready=1 → npc=32'h3004, pc_en=1, state=RUN.
- Branch with DELAY_SLOT=1: br_taken=1, br_target=32'h3040 → same cycle npc=32'h3040, pc_en=1, flush_if=0. Repeat with DELAY_SLOT=0 → flush_if=1.
- Redirect during stall: stall=1 with jump=1, jump_target=32'h3100 → pc_en=0, state=PEND. Next cycle br_taken=1, br_target=32'h3200 → ignored. Drop stall → npc=32'h3100, pc_en=1, state returns to RUN.
- Exception:
  - exc=1, exc_pc=32'h3008, stall=1, imem_ready=1 → epc=32'h3008 after the edge, npc=32'h4180, pc_en=1, flush_if=1, then state=FLUSH.
  - br_taken=1 in the FLUSH cycle → ignored, npc=pc+4.
- Exception overrides pending jump, then eret: imem_ready=0 with pending jump, then exc=1 → pending target becomes 32'h4180. imem_ready=1 → npc=32'h4180, flush_if=1. Later eret=1 → npc=epc, flush_if=1.
- Reset mid-PEND, plus wrap: reset=0 while in PEND → state=RUN, pending cleared, npc=32'h3000. Separately, pc=32'hFFFFFFFC → npc=32'h00000000.
